// File: rtl/junction_scheduler_if.sv
// rtl/junction_scheduler_if.sv - approach request / junction service bundle for junction_scheduler
// The emg_req lane exists only when JS_EMERGENCY_EN is defined.
interface junction_scheduler_if;
  logic [3:0] req;
  logic [7:0] path_n;
  logic [7:0] path_w;
  logic [7:0] path_e;
  logic [7:0] path_s;
  logic [3:0] ack;
  logic [3:0] grant;
  logic [1:0] in_dir;
  logic [1:0] out_dir;
  logic       NL;
  logic       SL;
  logic       EL;
  logic       WL;
  logic [7:0] new_path;
  logic       pass_valid;
  logic       arrived;
  logic       busy;
`ifdef JS_EMERGENCY_EN
  logic [3:0] emg_req;

  modport master (
    output req, path_n, path_w, path_e, path_s, emg_req,
    input  ack, grant, in_dir, out_dir, NL, SL, EL, WL, new_path, pass_valid, arrived, busy
  );
  modport slave (
    input  req, path_n, path_w, path_e, path_s, emg_req,
    output ack, grant, in_dir, out_dir, NL, SL, EL, WL, new_path, pass_valid, arrived, busy
  );
`else
  modport master (
    output req, path_n, path_w, path_e, path_s,
    input  ack, grant, in_dir, out_dir, NL, SL, EL, WL, new_path, pass_valid, arrived, busy
  );
  modport slave (
    input  req, path_n, path_w, path_e, path_s,
    output ack, grant, in_dir, out_dir, NL, SL, EL, WL, new_path, pass_valid, arrived, busy
  );
`endif
endinterface

// File: rtl/junction_scheduler.sv
// rtl/junction_scheduler.sv - round-robin four-way junction scheduler with timed exit lamps
// Optional JS_EMERGENCY_EN adds fixed-priority emergency requests that bypass the round-robin pointer.
module junction_scheduler #(
  parameter int DWELL = 4,
  parameter int CLEAR = 2,
  parameter int CW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  junction_scheduler_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LAMP = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [CW-1:0] DWELL_N = (DWELL == 0) ? CW'(1) : CW'(DWELL);
  localparam logic [CW-1:0] CLEAR_N = CW'(CLEAR);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [1:0]    state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [1:0]    in_dir_r;
  logic [1:0]    out_dir_r;
  logic [7:0]    new_path_r;
  logic          hop_zero_r;
  logic [3:0]    ack_r;
  logic          pass_r;
  logic          arr_r;

  logic [7:0] path_a [4];
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic [1:0] hop;
`ifdef JS_EMERGENCY_EN
  logic       emg_win;
`endif

  assign path_a[0] = bus.path_n;
  assign path_a[1] = bus.path_w;
  assign path_a[2] = bus.path_e;
  assign path_a[3] = bus.path_s;

  function automatic logic [1:0] exit_dir(input logic [1:0] d, input logic [1:0] i);
    logic [1:0] r;
    case (d)
      2'b01:   r = {~i[0], i[1]};
      2'b10:   r = {i[0], ~i[1]};
      2'b11:   r = {i[1], i[0]};
      default: r = {~i[1], ~i[0]};
    endcase
    return r;
  endfunction

  // Round-robin scan starts at ptr; an emergency request overrides the scan result.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int j = 0; j < 4; j++) begin
      idx = ptr + 2'(j);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`ifdef JS_EMERGENCY_EN
    emg_win = 1'b0;
    if (|bus.emg_req) begin
      found   = 1'b1;
      emg_win = 1'b1;
      for (int j = 3; j >= 0; j--) begin
        if (bus.emg_req[j]) win = 2'(j);
      end
    end
`endif
  end

  assign hop = path_a[win][7:6];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      cnt        <= '0;
      in_dir_r   <= 2'd0;
      out_dir_r  <= 2'd0;
      new_path_r <= 8'd0;
      hop_zero_r <= 1'b0;
      ack_r      <= 4'd0;
      pass_r     <= 1'b0;
      arr_r      <= 1'b0;
    end else begin
      ack_r  <= 4'd0;
      pass_r <= 1'b0;
      arr_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state      <= LAMP;
            in_dir_r   <= win;
            out_dir_r  <= exit_dir(hop, win);
            new_path_r <= {path_a[win][5:0], 2'b00};
            hop_zero_r <= (hop == 2'b00);
            ack_r      <= 4'b0001 << win;
            pass_r     <= 1'b1;
            arr_r      <= (hop == 2'b00);
            cnt        <= (hop == 2'b00) ? ONE : DWELL_N;
`ifdef JS_EMERGENCY_EN
            if (!emg_win) ptr <= win + 2'd1;
`else
            ptr <= win + 2'd1;
`endif
          end
        end
        LAMP: begin
          if (cnt <= ONE) begin
            if (CLEAR_N == '0) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              state <= GAP;
              cnt   <= CLEAR_N;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        GAP: begin
          if (cnt <= ONE) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Lamps and grant are pure decodes of the held service, so they drop the instant LAMP ends.
  logic lamp_on;
  assign lamp_on = (state == LAMP) && !hop_zero_r;

  assign bus.busy       = (state != IDLE);
  assign bus.grant      = (state == LAMP) ? (4'b0001 << in_dir_r) : 4'b0000;
  assign bus.in_dir     = in_dir_r;
  assign bus.out_dir    = out_dir_r;
  assign bus.new_path   = new_path_r;
  assign bus.ack        = ack_r;
  assign bus.pass_valid = pass_r;
  assign bus.arrived    = arr_r;
  assign bus.NL         = lamp_on && (out_dir_r == 2'b00);
  assign bus.WL         = lamp_on && (out_dir_r == 2'b01);
  assign bus.EL         = lamp_on && (out_dir_r == 2'b10);
  assign bus.SL         = lamp_on && (out_dir_r == 2'b11);

endmodule

// File: tb/tb_junction_scheduler.sv
// tb/tb_junction_scheduler.sv - randomized bench for junction_scheduler against a service-timeline model
// Directed scenarios first, then random traffic, resets and (with JS_EMERGENCY_EN) emergency requests.
module tb_junction_scheduler;
  localparam int DWELL = 4;
  localparam int CLEAR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  junction_scheduler_if bus ();
  junction_scheduler #(.DWELL(DWELL), .CLEAR(CLEAR), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [3:0] req_v;
  logic [3:0] emg_v;
  logic [7:0] path_v [4];
  int         left [4];
  bit         rnd;

  // Model: a service is a timeline indexed by k = cycles since the accepting edge.
  bit         m_act;
  int         m_k, m_win, m_ptr, m_len, m_tot;
  bit         m_emg;
  logic [1:0] m_hop, m_out;
  logic [7:0] m_np;

  logic [3:0] g_grant [$];
  int         g_cyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [1:0] exit_ref(input logic [1:0] d, input logic [1:0] i);
    case (d)
      2'b01:   return {~i[0], i[1]};
      2'b10:   return {i[0], ~i[1]};
      2'b11:   return {i[1], i[0]};
      default: return {~i[1], ~i[0]};
    endcase
  endfunction

  task automatic drive();
    bus.req    = req_v;
    bus.path_n = path_v[0];
    bus.path_w = path_v[1];
    bus.path_e = path_v[2];
    bus.path_s = path_v[3];
`ifdef JS_EMERGENCY_EN
    bus.emg_req = emg_v;
`endif
  endtask

  task automatic model_edge();
    int c;
    bit got;
    if (rst) begin
      m_act = 0;
      m_ptr = 0;
    end else if (m_act) begin
      m_k++;
      if (m_k > m_tot) m_act = 0;
    end else begin
      got = 0;
      c = 0;
`ifdef JS_EMERGENCY_EN
      if (emg_v != 0) begin
        for (int j = 3; j >= 0; j--) if (emg_v[j]) c = j;
        got = 1;
        m_emg = 1;
      end
`endif
      if (!got && req_v != 0) begin
        for (int j = 3; j >= 0; j--) if (req_v[(m_ptr + j) % 4]) c = (m_ptr + j) % 4;
        m_ptr = (c + 1) % 4;
        m_emg = 0;
        got = 1;
      end
      if (got) begin
        m_act = 1;
        m_k   = 1;
        m_win = c;
        m_hop = path_v[c][7:6];
        m_out = exit_ref(m_hop, 2'(c));
        m_np  = 8'((path_v[c] * 4) % 256);
        m_len = (m_hop == 0) ? 1 : ((DWELL == 0) ? 1 : DWELL);
        m_tot = m_len + CLEAR;
      end
    end
  endtask

  task automatic compare();
    logic [3:0] lamps;
    bit in_lamp;
    bit first;
    lamps   = {bus.SL, bus.EL, bus.WL, bus.NL};
    in_lamp = m_act && (m_k <= m_len);
    first   = m_act && (m_k == 1);
    check("busy", bus.busy, m_act);
    check("grant", bus.grant, in_lamp ? (4'b0001 << m_win) : 4'b0000);
    check("lamps", lamps, (in_lamp && m_hop != 0) ? (4'b0001 << m_out) : 4'b0000);
    check("ack", bus.ack, first ? (4'b0001 << m_win) : 4'b0000);
    check("pass_valid", bus.pass_valid, first);
    check("arrived", bus.arrived, first && (m_hop == 0));
    if (in_lamp) check("in_dir", bus.in_dir, m_win);
    if (first) begin
      check("out_dir", bus.out_dir, m_out);
      check("new_path", bus.new_path, m_np);
    end
    if (rst) begin
      check("rst_in_dir", bus.in_dir, 0);
      check("rst_out_dir", bus.out_dir, 0);
      check("rst_new_path", bus.new_path, 0);
    end
    if (bus.ack != 0) begin
      g_grant.push_back(bus.grant);
      g_cyc.push_back(cyc);
    end
  endtask

  task automatic stimulus();
    if (m_act && m_k == 1) begin
      if (m_emg) emg_v[m_win] = 1'b0;
      else if (left[m_win] > 0) begin
        left[m_win]--;
        if (rnd) path_v[m_win] = 8'($urandom);
      end else req_v[m_win] = 1'b0;
    end
    if (rnd) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_v[i]) begin
          path_v[i] = 8'($urandom);
          if ($urandom_range(0, 5) == 0) begin
            req_v[i] = 1'b1;
            left[i]  = $urandom_range(0, 2);
          end
        end
      end
`ifdef JS_EMERGENCY_EN
      if (emg_v == 0 && $urandom_range(0, 40) == 0) emg_v = 4'b0001 << $urandom_range(0, 3);
`endif
      rst = ($urandom_range(0, 300) == 0);
    end
    drive();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    compare();
    stimulus();
  endtask

  task automatic quiesce();
    req_v = 4'b0;
    emg_v = 4'b0;
    for (int i = 0; i < 4; i++) left[i] = 0;
    drive();
    repeat (10) tick();
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    req_v = 4'b0;
    emg_v = 4'b0;
    rnd = 0;
    m_act = 0;
    m_ptr = 0;
    m_emg = 0;
    for (int i = 0; i < 4; i++) begin
      path_v[i] = 8'h00;
      left[i] = 0;
    end
    drive();
    repeat (2) tick();
    rst = 1'b0;

    path_v[0] = 8'b0100_0000;
    req_v = 4'b0001;
    drive();
    repeat (10) tick();

    path_v[3] = 8'b1011_0000;
    req_v = 4'b1000;
    drive();
    repeat (10) tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    g_grant.delete();
    g_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      path_v[i] = 8'b1100_0000;
      left[i] = 2;
    end
    req_v = 4'b1111;
    drive();
    repeat (40) tick();
    check("fair_count", g_grant.size() >= 5, 1);
    for (int j = 0; j < 5 && j < g_grant.size(); j++) begin
      check("fair_order", g_grant[j], 4'b0001 << (j % 4));
      if (j > 0) check("fair_spacing", g_cyc[j] - g_cyc[j-1], 7);
    end
    quiesce();

    path_v[2] = 8'b0001_0101;
    req_v = 4'b0100;
    drive();
    repeat (8) tick();

    g_grant.delete();
    g_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      path_v[i] = 8'b1100_0000;
      left[i] = 5;
    end
    req_v = 4'b1111;
    drive();
    hit = 0;
    for (int t = 0; t < 20 && !hit; t++) begin
      tick();
      if (m_act && m_k == 2) hit = 1;
    end
    check("rst_lamp2_reached", hit, 1);
    rst = 1'b1;
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_grant", bus.grant, 0);
    rst = 1'b0;
    repeat (10) tick();
    check("rst_pre_grant", (g_grant.size() > 0) ? g_grant[0] : 4'b0, 4'b1000);
    check("rst_post_grant", (g_grant.size() > 1) ? g_grant[1] : 4'b0, 4'b0001);
    quiesce();

`ifdef JS_EMERGENCY_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    g_grant.delete();
    g_cyc.delete();
    path_v[0] = 8'b0100_0000;
    path_v[3] = 8'b1100_0000;
    req_v = 4'b0001;
    emg_v = 4'b1000;
    drive();
    repeat (20) tick();
    check("emg_first", (g_grant.size() > 0) ? g_grant[0] : 4'b0, 4'b1000);
    check("emg_then_n", (g_grant.size() > 1) ? g_grant[1] : 4'b0, 4'b0001);
    quiesce();
`endif

    rnd = 1;
    repeat (3000) tick();
    rnd = 0;
    rst = 1'b0;
    quiesce();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/junction_scheduler.md
# junction_scheduler

Sequential controller that shares one four-way junction between vehicles queued on its four approaches (N, W, E, S). It grants one approach at a time, round-robin. For the granted vehicle it decodes the next 2-bit route hop, drives the matching exit lamp for a fixed dwell, then holds a clearance gap before serving the next approach. It also hands the shifted route word downstream and sits directly upstream of the parking-lot routing junctions.

## Interface
Parameters:
- DWELL, 4, lamp-on cycles per vehicle; 0 is treated as 1
- CLEAR, 2, all-lamps-off gap after each vehicle; 0 allowed (no gap)
- CW, 8, width of the dwell/clear counter

Ports (direction code N=00, W=01, E=10, S=11; `req`/`ack`/`grant` bit index equals the code):
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  4  per-approach vehicle waiting; level, held until acked
- path_n, path_w, path_e, path_s  in  8 each  route word of the waiting vehicle; bits [7:6] are the next hop
- ack  out  4  one-hot, 1-cycle pulse: vehicle accepted, requester may drop `req` or present the next vehicle
- grant  out  4  one-hot approach currently being served
- in_dir  out  2  code of the served approach
- out_dir  out  2  computed exit direction
- NL, SL, EL, WL  out  1 each  exit lamps for codes 00, 11, 10, 01
- new_path  out  8  served route word shifted left by 2 (zero-fill)
- pass_valid  out  1  1-cycle pulse, `new_path`/`out_dir` valid for downstream
- arrived  out  1  1-cycle pulse, served hop was 00 (destination reached, no lamp)
- busy  out  1  state != IDLE
- emg_req  in  4  emergency request per approach; present only with JS_EMERGENCY_EN

## Operation
- States: IDLE, LAMP, GAP.
- **IDLE.** If any request bit is set, choose the winner round-robin starting from `ptr`, the approach after the last one served.
  - Latch the winner's code, its path word, its `new_path` and its `out_dir`.
  - Move to LAMP and set `ptr` to winner+1 mod 4.
  - With no request, stay in IDLE.
- **Exit-direction function** (d = hop bits [7:6], i = `in_dir`):
  - d=01 → {~i[0], i[1]}
  - d=10 → {i[0], ~i[1]}
  - d=11 → {i[1], i[0]}
  - d=00 → {~i[1], ~i[0]}; lamps stay off and `arrived` is pulsed instead
- **LAMP.**
  - `grant` and `in_dir` are held for the whole state.
  - The lamp matching `out_dir` stays high for DWELL cycles.
  - `ack`, `pass_valid` and `arrived` pulse on the first LAMP cycle only.
  - When d=00, LAMP lasts exactly 1 cycle with all lamps off.
- **GAP.** All lamps and `grant` are low for CLEAR cycles, then the FSM returns to IDLE. With CLEAR=0, LAMP goes directly to IDLE.
- Path words and `req` are sampled only in IDLE. Changes during LAMP/GAP are ignored.
- A `req` still high after its `ack` counts as a new vehicle.
- At most one lamp is high in any cycle. All lamps are low outside LAMP.

## Timing
- **Reset** (takes effect at the next edge, from any state, mid-service included):
  - state IDLE, `ptr`=N, counter 0
  - `ack`, `grant`, lamps, `pass_valid`, `arrived`, `busy` = 0
  - `in_dir`, `out_dir` = 00; `new_path` = 0
- **Latency.** `req` high in IDLE at edge k gives `grant`, lamp, `ack` and `pass_valid` high after edge k (cycle k+1).
- **Service period:** 1 + DWELL + CLEAR cycles per vehicle, which is 7 at defaults. Back-to-back grants are therefore 7 cycles apart.
- **Fairness.** With all four `req` held high after reset, the service order is N, W, E, S, N, …. No approach waits more than 3 services.
- The counter saturates and cannot wrap within a CW-bit range; DWELL and CLEAR must each be < 2^CW.

## Configuration
- **JS_EMERGENCY_EN defined:**
  - Port `emg_req[3:0]` exists.
  - In IDLE, any `emg_req` bit beats all `req` bits.
  - Among emergency bits, the fixed priority is N > W > E > S.
  - `ack` is returned on the same bit index.
  - Emergency grants do not update `ptr`.
  - Each service still runs the full LAMP and GAP.
- **Not defined:** the `emg_req` port is absent and arbitration is pure round-robin.

## Test plan
- Reset, then `req`=0001 with `path_n`=8'b01000000:
  - cycle 1: `grant`=0001, EL=1, `out_dir`=10, `new_path`=0, `ack`=0001, `pass_valid`=1
  - EL high cycles 1–4, all lamps low cycles 5–6, `busy` low at cycle 7
- `req`=1000 with `path_s`=8'b10110000: `out_dir`=10 (EL), `new_path`=8'b11000000.
- `req`=1111 held, each path hop 11: grant order 0001, 0010, 0100, 1000, 0001, with grants spaced exactly 7 cycles apart.
- `req`=0100 with `path_e`=8'b00xxxxxx: `arrived` pulses at cycle 1, all lamps stay 0, and `busy` is low by cycle 4 (1 LAMP + 2 GAP cycles).
- Assert `rst` during LAMP cycle 2: the next cycle has all outputs at reset values; with `req`=1111 the next grant is N.
- With JS_EMERGENCY_EN: `req`=0001 and `emg_req`=1000 together → S is served first, then N, and `ptr` is unchanged by the S service.
